// File: rtl/nibble_serial_addsub_if.sv
// Bundles the request/result signals of nibble_serial_addsub.
//   master : requester side (drives start, op_sub, a and b; receives status and result)
//   slave  : engine side (receives the request; drives busy, done, result and flags)
interface nibble_serial_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract engine that processes one nibble per clock, least
// significant nibble first. The carry is chained from nibble to nibble through
// a register. Subtraction is computed as a + ~b + 1.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport; start/op_sub/a/b are sampled together, then busy,
//           a one-cycle done pulse, result, carry_out (sub: 1 = no borrow) and
//           the signed overflow flag are returned
module nibble_serial_addsub #(
   parameter int unsigned WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_addsub_if.slave bus
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned CntW    = $clog2(NIBBLES);
   localparam int unsigned Msb     = WIDTH - 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;          // already inverted when subtracting
   logic [CntW-1:0]  cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] part_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;
   logic             overflow_q;
   logic             busy_q;
   logic             done_q;

   // One 4-bit slice working on the nibble selected by the counter.
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [4:0]       nib_sum;
   logic [WIDTH-1:0] part_d;
   logic             last_nib;

   always_comb begin
      a_nib    = a_q[{cnt_q, 2'b00} +: 4];
      b_nib    = b_q[{cnt_q, 2'b00} +: 4];
      nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      part_d   = part_q;
      part_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
      last_nib = (cnt_q == CntW'(NIBBLES - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         part_q      <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.op_sub ? ~bus.b : bus.b;
                  carry_q <= bus.op_sub;   // the +1 of two's-complement negation
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               // start is deliberately not looked at here: requests during a run are dropped
               part_q  <= part_d;
               carry_q <= nib_sum[4];
               cnt_q   <= cnt_q + CntW'(1);
               if (last_nib) begin
                  result_q    <= part_d;
                  carry_out_q <= nib_sum[4];
                  overflow_q  <= (a_q[Msb] == b_q[Msb]) && (part_d[Msb] != a_q[Msb]);
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub at WIDTH=16 with hand-computed results.
module tb_nibble_serial_addsub;

   localparam int unsigned WIDTH = 16;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents a request for exactly one edge, then scrambles the operand ports
   // so that any late sampling shows up in the result.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.a      = a;
      bus.b      = b;
      bus.op_sub = sub;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.a      = 16'hDEAD;
      bus.b      = 16'hBEEF;
      bus.op_sub = ~sub;
      check_eq("busy_after_start", 32'(bus.busy), 32'd1);
      check_eq("done_after_start", 32'(bus.done), 32'd0);
   endtask

   // Called #1 after the start edge; walks the remaining edges up to done.
   task automatic expect_done(input string tag, input logic [15:0] res, input logic co,
                              input logic ov);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
         check_eq({tag, "_done_run"}, 32'(bus.done), 32'd0);
      end
      @(posedge clk);
      #1;
      check_eq({tag, "_done"},      32'(bus.done),      32'd1);
      check_eq({tag, "_busy_done"}, 32'(bus.busy),      32'd0);
      check_eq({tag, "_result"},    32'(bus.result),    32'(res));
      check_eq({tag, "_carry"},     32'(bus.carry_out), 32'(co));
      check_eq({tag, "_ovf"},       32'(bus.overflow),  32'(ov));
   endtask

   task automatic expect_idle_after(input string tag, input logic [15:0] res);
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, 32'(bus.done),   32'd0);
      check_eq({tag, "_hold"},       32'(bus.result), 32'(res));
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.op_sub = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      #12;
      check_eq("rst_busy",   32'(bus.busy),      32'd0);
      check_eq("rst_done",   32'(bus.done),      32'd0);
      check_eq("rst_result", 32'(bus.result),    32'd0);
      check_eq("rst_carry",  32'(bus.carry_out), 32'd0);
      check_eq("rst_ovf",    32'(bus.overflow),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      start_op(16'h1234, 16'h0FCD, 1'b0);
      expect_done("add_basic", 16'h2201, 1'b0, 1'b0);
      expect_idle_after("add_basic", 16'h2201);

      start_op(16'hFFFF, 16'h0001, 1'b0);
      expect_done("add_ripple", 16'h0000, 1'b1, 1'b0);
      expect_idle_after("add_ripple", 16'h0000);

      start_op(16'h7FFF, 16'h0001, 1'b0);
      expect_done("add_ovf", 16'h8000, 1'b0, 1'b1);
      expect_idle_after("add_ovf", 16'h8000);

      start_op(16'h8000, 16'h0001, 1'b1);
      expect_done("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
      expect_idle_after("sub_ovf", 16'h7FFF);

      start_op(16'h0005, 16'h0003, 1'b1);
      expect_done("sub_pos", 16'h0002, 1'b1, 1'b0);
      expect_idle_after("sub_pos", 16'h0002);

      start_op(16'h0003, 16'h0005, 1'b1);
      expect_done("sub_neg", 16'hFFFE, 1'b0, 1'b0);
      expect_idle_after("sub_neg", 16'hFFFE);

      // Start pulsed during cycle 2 of a run must be ignored.
      start_op(16'h1234, 16'h0FCD, 1'b0);
      @(posedge clk);
      #1;
      check_eq("ign_busy1", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.a      = 16'h0001;
      bus.b      = 16'h0001;
      bus.op_sub = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_eq("ign_busy2", 32'(bus.busy), 32'd1);
      check_eq("ign_done2", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
      check_eq("ign_busy3", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      check_eq("ign_done",   32'(bus.done),   32'd1);
      check_eq("ign_result", 32'(bus.result), 32'h2201);
      // Back-to-back: start presented in the DONE cycle is accepted.
      start_op(16'h00FF, 16'h0F01, 1'b0);
      expect_done("b2b", 16'h1000, 1'b0, 1'b0);
      expect_idle_after("b2b", 16'h1000);

      // Asynchronous reset between edges during cycle 2 of a run.
      start_op(16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy",   32'(bus.busy),      32'd0);
      check_eq("arst_done",   32'(bus.done),      32'd0);
      check_eq("arst_result", 32'(bus.result),    32'd0);
      check_eq("arst_carry",  32'(bus.carry_out), 32'd0);
      check_eq("arst_ovf",    32'(bus.overflow),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check_eq("arst_no_done", 32'(bus.done), 32'd0);
         check_eq("arst_no_busy", 32'(bus.busy), 32'd0);
      end

      start_op(16'hA5A5, 16'h5A5A, 1'b1);
      expect_done("post_rst", 16'h4B4B, 1'b1, 1'b1);
      expect_idle_after("post_rst", 16'h4B4B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case something above never returns.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected bench to finish");
      $fatal(1, "timeout");
   end

endmodule
